// File: rtl/accel_resp_pkg.sv
// Shared constants and state type for the ADXL362-style SPI responder.
// Build option: SPI_RESP_WRITE_EN enables the 0x0A write command and POWER_CTL.
package accel_resp_pkg;

    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h0A;

    localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
    localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
    localparam logic [5:0] ADDR_PARTID    = 6'h02;
    localparam logic [5:0] ADDR_XDATA     = 6'h08;
    localparam logic [5:0] ADDR_YDATA     = 6'h09;
    localparam logic [5:0] ADDR_ZDATA     = 6'h0A;
    localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
    localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
    localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
    localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
    localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
    localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
    localparam logic [5:0] ADDR_POWER_CTL = 6'h2D;

    localparam logic [7:0] ID_DEVID_AD  = 8'hAD;
    localparam logic [7:0] ID_DEVID_MST = 8'h1D;
    localparam logic [7:0] ID_PARTID    = 8'hF2;

    localparam logic [7:0] POWER_CTL_RST = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        IGNORE
    } resp_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronisers for sclk/ncs/mosi plus registered rise/fall pulses.
// Chains reset to 0 so a low ncs at reset release shows no falling edge.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstbt,
    input  logic sclk,
    input  logic ncs,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ncs_rise,
    output logic ncs_fall,
    output logic ncs_lvl,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic ncs_prev_q, ncs_prev_d;
    logic sclk_rise_q, sclk_rise_d;
    logic sclk_fall_q, sclk_fall_d;
    logic ncs_rise_q, ncs_rise_d;
    logic ncs_fall_q, ncs_fall_d;
    logic mosi_q, mosi_d;

    // shift pins through the chains; edges compare last stage to its delay
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        ncs_prev_d  = ncs_sync_q[SYNC_STAGES-1];
        sclk_rise_d = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
        sclk_fall_d = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
        ncs_rise_d  = ncs_sync_q[SYNC_STAGES-1] & ~ncs_prev_q;
        ncs_fall_d  = ~ncs_sync_q[SYNC_STAGES-1] & ncs_prev_q;
        mosi_d      = mosi_sync_q[SYNC_STAGES-1];
    end

    // synchroniser and edge-detect registers
    always_ff @(posedge clk or negedge rstbt) begin
        if (!rstbt) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ncs_rise_q  <= 1'b0;
            ncs_fall_q  <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ncs_prev_q  <= ncs_prev_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            ncs_rise_q  <= ncs_rise_d;
            ncs_fall_q  <= ncs_fall_d;
            mosi_q      <= mosi_d;
        end
    end

    assign sclk_rise = sclk_rise_q;
    assign sclk_fall = sclk_fall_q;
    assign ncs_rise  = ncs_rise_q;
    assign ncs_fall  = ncs_fall_q;
    assign ncs_lvl   = ncs_prev_q;
    assign mosi_s    = mosi_q;

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave emulating an ADXL362 register map for HIL/sim builds.
// Build option: SPI_RESP_WRITE_EN enables writes to POWER_CTL and standby masking.
module spi_accel_responder
    import accel_resp_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstbt,
    input  logic        sclk,
    input  logic        ncs,
    input  logic        mosi,
    output logic        miso,
    input  logic [11:0] x_in,
    input  logic [11:0] y_in,
    input  logic [11:0] z_in,
    output logic        busy,
    output logic        rd_strobe,
    output logic [7:0]  power_ctl
);

    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, ncs_lvl, mosi_s;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rstbt    (rstbt),
        .sclk     (sclk),
        .ncs      (ncs),
        .mosi     (mosi),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .ncs_rise (ncs_rise),
        .ncs_fall (ncs_fall),
        .ncs_lvl  (ncs_lvl),
        .mosi_s   (mosi_s)
    );

    resp_state_t state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  out_cnt_q, out_cnt_d;
    logic [7:0]  sh_in_q, sh_in_d;
    logic [7:0]  sh_out_q, sh_out_d;
    logic [5:0]  addr_q, addr_d;
    logic        is_read_q, is_read_d;
    logic        miso_q, miso_d;
    logic        busy_q, busy_d;
    logic        rd_strobe_q, rd_strobe_d;
    logic [11:0] x_q, x_d, y_q, y_d, z_q, z_d;

    logic [7:0]  rx_byte;
    logic [5:0]  nxt_addr;
    logic [7:0]  pc_cur;
    logic        meas;

    assign rx_byte  = {sh_in_q[6:0], mosi_s};
    assign nxt_addr = addr_q + 6'd1;

`ifdef SPI_RESP_WRITE_EN
    logic [7:0] pc_q, pc_d;
    assign pc_cur = pc_q;
    assign meas   = (pc_q[1:0] == 2'b10);
`else
    assign pc_cur = POWER_CTL_RST;
    assign meas   = 1'b1;
`endif

    function automatic logic [7:0] reg_val(
        input logic [5:0]  a,
        input logic [11:0] x,
        input logic [11:0] y,
        input logic [11:0] z,
        input logic [7:0]  pc,
        input logic        m
    );
        logic [7:0] v;
        case (a)
            ADDR_DEVID_AD:  v = ID_DEVID_AD;
            ADDR_DEVID_MST: v = ID_DEVID_MST;
            ADDR_PARTID:    v = ID_PARTID;
            ADDR_XDATA:     v = x[11:4];
            ADDR_YDATA:     v = y[11:4];
            ADDR_ZDATA:     v = z[11:4];
            ADDR_XDATA_L:   v = x[7:0];
            ADDR_XDATA_H:   v = {{4{x[11]}}, x[11:8]};
            ADDR_YDATA_L:   v = y[7:0];
            ADDR_YDATA_H:   v = {{4{y[11]}}, y[11:8]};
            ADDR_ZDATA_L:   v = z[7:0];
            ADDR_ZDATA_H:   v = {{4{z[11]}}, z[11:8]};
            ADDR_POWER_CTL: v = pc;
            default:        v = 8'h00;
        endcase
        if (!m && a >= ADDR_XDATA && a <= ADDR_ZDATA_H) begin
            v = 8'h00;
        end
        return v;
    endfunction

    // transaction FSM: byte framing, register mux, MISO shifting
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        out_cnt_d   = out_cnt_q;
        sh_in_d     = sh_in_q;
        sh_out_d    = sh_out_q;
        addr_d      = addr_q;
        is_read_d   = is_read_q;
        miso_d      = miso_q;
        busy_d      = busy_q;
        rd_strobe_d = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
`ifdef SPI_RESP_WRITE_EN
        pc_d        = pc_q;
`endif
        if (ncs_rise) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    miso_d = 1'b0;
                    if (ncs_fall) begin
                        state_d   = CMD;
                        busy_d    = 1'b1;
                        bit_cnt_d = 3'd0;
                        x_d       = x_in;
                        y_d       = y_in;
                        z_d       = z_in;
                    end else if (!ncs_lvl) begin
                        state_d = IGNORE;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        sh_in_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte == CMD_READ) begin
                                state_d   = ADDR;
                                is_read_d = 1'b1;
`ifdef SPI_RESP_WRITE_EN
                            end else if (rx_byte == CMD_WRITE) begin
                                state_d   = ADDR;
                                is_read_d = 1'b0;
`endif
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        sh_in_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d   = DATA;
                            addr_d    = rx_byte[5:0];
                            out_cnt_d = 3'd0;
                            sh_out_d  = reg_val(rx_byte[5:0], x_q, y_q,
                                                z_q, pc_cur, meas);
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        sh_in_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7 && !is_read_q) begin
                            addr_d = nxt_addr;
`ifdef SPI_RESP_WRITE_EN
                            if (addr_q == ADDR_POWER_CTL) begin
                                pc_d = rx_byte;
                            end
`endif
                        end
                    end else if (sclk_fall && is_read_q) begin
                        miso_d    = sh_out_q[7];
                        sh_out_d  = {sh_out_q[6:0], 1'b0};
                        out_cnt_d = out_cnt_q + 3'd1;
                        if (out_cnt_q == 3'd7) begin
                            rd_strobe_d = 1'b1;
                            addr_d      = nxt_addr;
                            sh_out_d    = reg_val(nxt_addr, x_q, y_q,
                                                  z_q, pc_cur, meas);
                        end
                    end
                end
                IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // state, datapath and snapshot registers
    always_ff @(posedge clk or negedge rstbt) begin
        if (!rstbt) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            out_cnt_q   <= 3'd0;
            sh_in_q     <= 8'h00;
            sh_out_q    <= 8'h00;
            addr_q      <= 6'd0;
            is_read_q   <= 1'b1;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            rd_strobe_q <= 1'b0;
            x_q         <= 12'd0;
            y_q         <= 12'd0;
            z_q         <= 12'd0;
`ifdef SPI_RESP_WRITE_EN
            pc_q        <= POWER_CTL_RST;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            out_cnt_q   <= out_cnt_d;
            sh_in_q     <= sh_in_d;
            sh_out_q    <= sh_out_d;
            addr_q      <= addr_d;
            is_read_q   <= is_read_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            rd_strobe_q <= rd_strobe_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
`ifdef SPI_RESP_WRITE_EN
            pc_q        <= pc_d;
`endif
        end
    end

    assign miso      = miso_q & ~ncs;
    assign busy      = busy_q;
    assign rd_strobe = rd_strobe_q;
    assign power_ctl = pc_cur;

endmodule

// File: doc/spi_accel_responder.md
# spi_accel_responder

SPI slave that emulates the ADXL362-style accelerometer on the `bo`/`bi` port, so the accelerometer SPI master and the ball-control path can be exercised without the physical sensor. It is used in hardware-in-the-loop builds and in simulation. The block answers register reads from a small register map. X, Y and Z acceleration values are supplied on input ports and frozen for the duration of each transaction. All SPI inputs are oversampled in the 50 MHz `clk` domain.

## Interface
- Parameters
  - `SYNC_STAGES`, default 2: synchroniser depth for `sclk`, `ncs` and `mosi`; legal values are 2 or 3.
- Ports
  - `clk`  in  1: 50 MHz system clock.
  - `rstbt`  in  1: reset, asynchronous, active-low.
  - `sclk`  in  1: SPI clock from the master, mode 0 (CPOL=0, CPHA=0).
  - `ncs`  in  1: chip select, active-low.
  - `mosi`  in  1: master-out data.
  - `miso`  out  1: slave-out data; driven 0 whenever `ncs` is high (no tristate).
  - `x_in`, `y_in`, `z_in`  in  12 each: signed acceleration values from the stimulus.
  - `busy`  out  1: high while a transaction is in progress.
  - `rd_strobe`  out  1: one-`clk` pulse per completed read data byte.
  - `power_ctl`  out  8: current POWER_CTL register value.

## Operation
- Command bytes: 0x0B = read, 0x0A = write. Each transaction is a command byte, then an address byte, then N data bytes, all MSB first.
- States and transitions:
  - IDLE → CMD on `ncs` falling.
  - CMD → ADDR after 8 bits if the command is valid. Any other command → IGNORE.
  - ADDR → DATA after 8 bits.
  - DATA loops per byte. The address auto-increments after every byte and wraps 0x3F→0x00.
  - Any state → IDLE on `ncs` rising. An incomplete byte is discarded and no write takes effect.
- Snapshot: `x_in`/`y_in`/`z_in` are captured on the detected `ncs` falling edge. All reads within that transaction return the snapshot.
- Register map (6-bit address; unmapped addresses read 0x00):
  - 0x00 = 0xAD, 0x01 = 0x1D, 0x02 = 0xF2.
  - 0x08/0x09/0x0A = `x[11:4]` / `y[11:4]` / `z[11:4]`.
  - 0x0E/0x0F = `x[7:0]` / {4×`x[11]`, `x[11:8]`}.
  - 0x10/0x11 = same encoding for y; 0x12/0x13 = same encoding for z.
  - 0x2D = POWER_CTL.
- Standby: when `power_ctl[1:0]` ≠ 2'b10, addresses 0x08–0x13 read 0x00.
- Bit handling: MOSI is sampled on detected `sclk` rising. MISO shifts on detected `sclk` falling.
- First read data bit: the MSB of the first data byte is presented on the falling edge that follows the eighth address bit.
- Reset values: `miso`=0, `busy`=0, `rd_strobe`=0, `power_ctl`=0x02 (measurement mode), state IDLE, snapshot 0.
- Reset released while `ncs` is low: the block enters IGNORE and accepts nothing until `ncs` has been high.

## Timing
- Input path latency: `SYNC_STAGES` cycles of synchronisation plus 1 cycle of edge detection.
- MISO update: `miso` changes at most `SYNC_STAGES`+2 `clk` cycles after the `sclk` falling edge.
- Supported SCLK: half-period ≥ 4 `clk` cycles (80 ns), i.e. `sclk` ≤ 6.25 MHz. Behaviour at faster clocks is undefined.
- `ncs` setup: `ncs` falling must precede the first `sclk` rising by ≥ 4 `clk` cycles.
- `busy`: rises 1 cycle after detected `ncs` falling; falls 1 cycle after detected `ncs` rising.
- `rd_strobe`: fires on the cycle the eighth bit of a read data byte is shifted out.
- Simultaneous `ncs` rising and `sclk` edge: `ncs` wins and the `sclk` edge is ignored.

## Configuration
- `SPI_RESP_WRITE_EN`
  - Defined: the 0x0A write command is accepted. A complete data byte to 0x2D updates POWER_CTL in the cycle after its eighth bit. Writes to any other address are ignored.
  - Undefined: 0x0A sends the block to IGNORE. POWER_CTL is hard-wired to 0x02, and the standby masking logic is removed.

## Structure
- Package `accel_resp_pkg` holds:
  - command codes (`CMD_READ`, `CMD_WRITE`);
  - register address constants;
  - ID constants;
  - state enum `resp_state_t` with values IDLE, CMD, ADDR, DATA, IGNORE.
- Sub-module `spi_sync_edge`: `SYNC_STAGES`-deep synchronisers on `sclk`, `ncs` and `mosi`, plus rise/fall detect for `sclk` and `ncs`.
- The top level contains the FSM, the 3-bit bit counter, the shift registers, the register mux and the snapshot registers.

## Test plan
- Read 0x0B, 0x00, then 3 bytes at 1 MHz → MISO returns 0xAD, 0x1D, 0xF2; `rd_strobe` pulses 3 times.
- `x_in`=0x9A5, burst read from 0x0E, `x_in` changed mid-transfer → returns 0xA5, 0xF9; the change is not seen.
- Read from 0x3F, 2 bytes → returns 0x00 then 0xAD (address wrap).
- `ncs` raised after 5 bits of a write 0x00 to 0x2D, then a read of 0x2D → returns 0x02.
- With `SPI_RESP_WRITE_EN`: write 0x00 to 0x2D, then read 0x08 → returns 0x00. Without the macro, the same sequence → read returns `x[11:4]`.
- Command 0x55 → `miso` stays 0 until `ncs` rises. `rstbt` pulsed mid-read → outputs return to reset values and the next full read succeeds.
